// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller for a 2-way set-associative, write-back cache.
// Sequences tag compare, dirty-victim writeback, line refill and tag update,
// and drives the tag/line/status array strobes and the word-wide memory port.
module cache_miss_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 6,
    parameter int WORD_W  = 2,
    localparam int TAG_W  = ADDR_W - INDEX_W - WORD_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        hit,
    input  logic [1:0]        valid,
    input  logic [1:0]        dirty,
    input  logic              victim,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic              mem_ack,
    output logic              busy,
    output logic              compare_en,
    output logic              cpu_ready,
    output logic              way_sel,
    output logic              line_we,
    output logic [WORD_W-1:0] line_word,
    output logic              tag_we,
    output logic              dirty_set,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_UPDATE
    } state_t;

    localparam logic [WORD_W-1:0] CNT_LAST = '1;

    state_t              state;
    logic [WORD_W-1:0]   cnt;
    logic [ADDR_W-1:2]   addr_q;
    logic                we_q;
    logic                vic_q;
    logic [TAG_W-1:0]    vtag_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;

    // Byte offset never reaches the controller; memory traffic is word-aligned.
    logic                unused_byte_offset;
    assign unused_byte_offset = ^cpu_addr[1:0];

    assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign req_index = addr_q[WORD_W+2 +: INDEX_W];

    // State sequencing, refill/writeback word counter and request/victim latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            vic_q  <= 1'b0;
            vtag_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q <= cpu_addr[ADDR_W-1:2];
                        we_q   <= cpu_we;
                        state  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (hit == 2'b00) begin
                        vic_q  <= victim;
                        vtag_q <= victim_tag;
                        cnt    <= '0;
                        state  <= (valid[victim] & dirty[victim]) ? S_WRITEBACK : S_ALLOCATE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    state <= S_COMPARE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: hit completion and refill strobes follow hit/mem_ack in the same cycle.
    always_comb begin
        busy       = (state != S_IDLE);
        compare_en = (state == S_COMPARE);
        cpu_ready  = 1'b0;
        dirty_set  = 1'b0;
        way_sel    = 1'b0;
        line_we    = 1'b0;
        line_word  = cnt;
        tag_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        case (state)
            S_COMPARE: begin
                line_word = addr_q[WORD_W+1:2];
                if (hit != 2'b00) begin
                    cpu_ready = 1'b1;
                    dirty_set = we_q;
                    way_sel   = ~hit[0];
                end
            end
            S_WRITEBACK: begin
                way_sel  = vic_q;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {vtag_q, req_index, cnt, 2'b00};
            end
            S_ALLOCATE: begin
                way_sel  = vic_q;
                mem_req  = 1'b1;
                line_we  = mem_ack;
                mem_addr = {req_tag, req_index, cnt, 2'b00};
            end
            S_UPDATE: begin
                way_sel = vic_q;
                tag_we  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: directed accesses push the expected
// completion, memory-transfer and tag-update events; a negedge monitor pops
// and compares each event the controller presents.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [1:0]  hit;
    logic [1:0]  valid;
    logic [1:0]  dirty;
    logic        victim;
    logic [21:0] victim_tag;
    logic        mem_ack;
    logic        busy;
    logic        compare_en;
    logic        cpu_ready;
    logic        way_sel;
    logic        line_we;
    logic [1:0]  line_word;
    logic        tag_we;
    logic        dirty_set;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 ready, 1 memory word, 2 tag write
        logic [31:0] addr;
        logic        we;
        logic        way;
        logic        flag;   // dirty_set for ready, line_we for memory word
        logic [1:0]  word;
    } ev_t;

    ev_t sb[$];

    cache_miss_ctrl #(.ADDR_W(32), .INDEX_W(6), .WORD_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .hit        (hit),
        .valid      (valid),
        .dirty      (dirty),
        .victim     (victim),
        .victim_tag (victim_tag),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .compare_en (compare_en),
        .cpu_ready  (cpu_ready),
        .way_sel    (way_sel),
        .line_we    (line_we),
        .line_word  (line_word),
        .tag_we     (tag_we),
        .dirty_set  (dirty_set),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr)
    );

    always #5 clk = ~clk;

    function automatic void push_rdy(input logic way, input logic ds);
        sb.push_back('{kind: 2'd0, addr: 32'h0, we: 1'b0, way: way, flag: ds, word: 2'd0});
    endfunction

    function automatic void push_mem(input logic [31:0] a, input logic we, input logic way,
                                     input logic lwe, input logic [1:0] word);
        sb.push_back('{kind: 2'd1, addr: a, we: we, way: way, flag: lwe, word: word});
    endfunction

    function automatic void push_tag(input logic way);
        sb.push_back('{kind: 2'd2, addr: 32'h0, we: 1'b0, way: way, flag: 1'b0, word: 2'd0});
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: every event the controller presents must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (cpu_ready || tag_we || (mem_req && mem_ack))) begin
            ev_t got;
            ev_t exp;
            got = '0;
            if (cpu_ready) begin
                got.kind = 2'd0; got.way = way_sel; got.flag = dirty_set;
            end else if (tag_we) begin
                got.kind = 2'd2; got.way = way_sel;
            end else begin
                got.kind = 2'd1; got.addr = mem_addr; got.we = mem_we;
                got.way = way_sel; got.flag = line_we; got.word = line_word;
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", got, exp);
                end
            end
        end
    end

    task automatic do_access(input string nm, input logic [31:0] a, input logic w,
                             input logic [1:0] h, input logic [1:0] v, input logic [1:0] d,
                             input logic vic, input logic [21:0] vt, input logic hold,
                             input int stall_word, input int stall_cyc,
                             input logic [31:0] stall_addr, input int exp_lat, input int exp_ce);
        int  n;
        int  ce;
        int  left;
        bit  done;
        cpu_addr = a; cpu_we = w; hit = h; valid = v; dirty = d;
        victim = vic; victim_tag = vt; mem_ack = 1'b0;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            cpu_req = 1'b0;
        end else begin
            cpu_addr = 32'hDEAD_0000;
            cpu_we   = ~w;
        end
        n = 1; ce = 0; left = stall_cyc; done = 0;
        while (!done && n <= 200) begin
            if (compare_en) ce++;
            if (tag_we) hit = vic ? 2'b10 : 2'b01;
            mem_ack = 1'b1;
            if (mem_req && !mem_we && int'(line_word) == stall_word && left > 0) begin
                mem_ack = 1'b0;
                left--;
                #1;
                chk({nm, "_stall_addr"}, 64'(mem_addr), 64'(stall_addr));
                chk({nm, "_stall_word"}, 64'(line_word), 64'(stall_word));
                chk({nm, "_stall_line_we"}, 64'(line_we), 64'd0);
            end
            if (cpu_ready) begin
                done    = 1;
                cpu_req = 1'b0;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
        chk({nm, "_completed"}, 64'(done), 64'd1);
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
        chk({nm, "_compare_cycles"}, 64'(ce), 64'(exp_ce));
        @(posedge clk); #1;
        chk({nm, "_idle_after"}, 64'(busy), 64'd0);
        hit = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        hit = '0; valid = '0; dirty = '0; victim = 1'b0; victim_tag = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({busy, compare_en, cpu_ready, way_sel, line_we, line_word, tag_we,
                 dirty_set, mem_req, mem_we, mem_addr}), 64'd0);
        rst_n = 1'b1;

        // Read hit in way 1
        push_rdy(1'b1, 1'b0);
        do_access("read_hit", 32'h0000_0040, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 22'h0,
                  1'b0, -1, 0, 32'h0, 1, 1);

        // Store hit in way 0
        push_rdy(1'b0, 1'b1);
        do_access("store_hit", 32'h0000_0104, 1'b1, 2'b01, 2'b11, 2'b00, 1'b1, 22'h0,
                  1'b0, -1, 0, 32'h0, 1, 1);

        // Both ways report a hit: way 0 wins
        push_rdy(1'b0, 1'b1);
        do_access("double_hit", 32'h0000_0208, 1'b1, 2'b11, 2'b11, 2'b11, 1'b1, 22'h0,
                  1'b0, -1, 0, 32'h0, 1, 1);

        // Clean miss, victim way 0
        push_mem(32'h0000_1230, 1'b0, 1'b0, 1'b1, 2'd0);
        push_mem(32'h0000_1234, 1'b0, 1'b0, 1'b1, 2'd1);
        push_mem(32'h0000_1238, 1'b0, 1'b0, 1'b1, 2'd2);
        push_mem(32'h0000_123C, 1'b0, 1'b0, 1'b1, 2'd3);
        push_tag(1'b0);
        push_rdy(1'b0, 1'b0);
        do_access("clean_miss", 32'h0000_1230, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 22'h3FF,
                  1'b0, -1, 0, 32'h0, 7, 2);

        // Dirty store miss, victim way 1; cpu_req held and address changed while busy
        push_mem(32'h002A_F230, 1'b1, 1'b1, 1'b0, 2'd0);
        push_mem(32'h002A_F234, 1'b1, 1'b1, 1'b0, 2'd1);
        push_mem(32'h002A_F238, 1'b1, 1'b1, 1'b0, 2'd2);
        push_mem(32'h002A_F23C, 1'b1, 1'b1, 1'b0, 2'd3);
        push_mem(32'h0000_1230, 1'b0, 1'b1, 1'b1, 2'd0);
        push_mem(32'h0000_1234, 1'b0, 1'b1, 1'b1, 2'd1);
        push_mem(32'h0000_1238, 1'b0, 1'b1, 1'b1, 2'd2);
        push_mem(32'h0000_123C, 1'b0, 1'b1, 1'b1, 2'd3);
        push_tag(1'b1);
        push_rdy(1'b1, 1'b1);
        do_access("dirty_miss", 32'h0000_1230, 1'b1, 2'b00, 2'b11, 2'b10, 1'b1, 22'h00ABC,
                  1'b1, -1, 0, 32'h0, 11, 2);

        // Dirty bit set on an invalid victim: no writeback; refill starts at word 0
        push_mem(32'h0000_5670, 1'b0, 1'b1, 1'b1, 2'd0);
        push_mem(32'h0000_5674, 1'b0, 1'b1, 1'b1, 2'd1);
        push_mem(32'h0000_5678, 1'b0, 1'b1, 1'b1, 2'd2);
        push_mem(32'h0000_567C, 1'b0, 1'b1, 1'b1, 2'd3);
        push_tag(1'b1);
        push_rdy(1'b1, 1'b0);
        do_access("invalid_dirty_victim", 32'h0000_5678, 1'b0, 2'b00, 2'b01, 2'b10, 1'b1,
                  22'h00123, 1'b0, -1, 0, 32'h0, 7, 2);

        // Memory stalls five cycles on word 2
        push_mem(32'h0000_1230, 1'b0, 1'b0, 1'b1, 2'd0);
        push_mem(32'h0000_1234, 1'b0, 1'b0, 1'b1, 2'd1);
        push_mem(32'h0000_1238, 1'b0, 1'b0, 1'b1, 2'd2);
        push_mem(32'h0000_123C, 1'b0, 1'b0, 1'b1, 2'd3);
        push_tag(1'b0);
        push_rdy(1'b0, 1'b0);
        do_access("stall_miss", 32'h0000_1230, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 22'h0,
                  1'b0, 2, 5, 32'h0000_1238, 12, 2);

        // Reset asserted mid-ALLOCATE after word 1 has been acknowledged
        push_mem(32'h0000_1230, 1'b0, 1'b0, 1'b1, 2'd0);
        push_mem(32'h0000_1234, 1'b0, 1'b0, 1'b1, 2'd1);
        cpu_addr = 32'h0000_1230; cpu_we = 1'b0; hit = 2'b00; valid = 2'b11;
        dirty = 2'b00; victim = 1'b0; victim_tag = '0; mem_ack = 1'b0;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_word", 64'(line_word), 64'd2);
        chk("pre_reset_mem_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mem_req", 64'(mem_req), 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_line_word", 64'(line_word), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh request right after reset release restarts at word 0
        push_mem(32'h0000_1230, 1'b0, 1'b0, 1'b1, 2'd0);
        push_mem(32'h0000_1234, 1'b0, 1'b0, 1'b1, 2'd1);
        push_mem(32'h0000_1238, 1'b0, 1'b0, 1'b1, 2'd2);
        push_mem(32'h0000_123C, 1'b0, 1'b0, 1'b1, 2'd3);
        push_tag(1'b0);
        push_rdy(1'b0, 1'b0);
        do_access("post_reset_miss", 32'h0000_1230, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 22'h0,
                  1'b0, -1, 0, 32'h0, 7, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
